// File: rtl/ram_write_arbiter.sv
// Write-port arbiter for the register-file RAM: ALU writeback has priority,
// multiplier results wait in a small FIFO that is forced through after a starvation limit.
module ram_write_arbiter #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 8,
   parameter int PTR_WIDTH    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iAluWriteEnable,
   input  logic [ADDR_WIDTH-1:0] iAluWriteAddress,
   input  logic [DATA_WIDTH-1:0] iAluDataIn,
   output logic                  oAluHold,
   input  logic                  iMulValid,
   input  logic [ADDR_WIDTH-1:0] iMulAddress,
   input  logic [DATA_WIDTH-1:0] iMulData,
   output logic                  oMulReady,
   input  logic [ADDR_WIDTH-1:0] iReadAddress0,
   input  logic [ADDR_WIDTH-1:0] iReadAddress1,
   output logic                  oWriteEnable,
   output logic [ADDR_WIDTH-1:0] oWriteAddress,
   output logic [DATA_WIDTH-1:0] oDataOut,
   output logic                  oStall,
   output logic [PTR_WIDTH:0]    oPendingCount
);

   localparam int PEND_DEPTH   = 2 ** PTR_WIDTH;
   localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);

   localparam logic [PTR_WIDTH:0]      FULL_COUNT = (PTR_WIDTH + 1)'(PEND_DEPTH);
   localparam logic [PTR_WIDTH:0]      COUNT_ONE  = (PTR_WIDTH + 1)'(1);
   localparam logic [PTR_WIDTH-1:0]    PTR_ONE    = PTR_WIDTH'(1);
   localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);
   localparam logic [STARVE_WIDTH-1:0] STARVE_ONE = STARVE_WIDTH'(1);

   localparam logic [1:0] GRANT_NONE  = 2'd0;
   localparam logic [1:0] GRANT_ALU   = 2'd1;
   localparam logic [1:0] GRANT_QUEUE = 2'd2;

   logic [ADDR_WIDTH-1:0]   queue_addr_r [PEND_DEPTH];
   logic [DATA_WIDTH-1:0]   queue_data_r [PEND_DEPTH];
   logic [PTR_WIDTH-1:0]    wr_ptr_r;
   logic [PTR_WIDTH-1:0]    rd_ptr_r;
   logic [PTR_WIDTH:0]      count_r;
   logic [STARVE_WIDTH-1:0] starve_r;
   logic [STARVE_WIDTH-1:0] starve_next_s;
   logic                    write_enable_r;
   logic [ADDR_WIDTH-1:0]   write_address_r;
   logic [DATA_WIDTH-1:0]   write_data_r;

   logic [1:0] grant_s;
   logic       queue_busy_s;
   logic       force_s;
   logic       mul_ready_s;
   logic       push_s;
   logic       pop_s;
   logic       hazard_s;
   logic [PTR_WIDTH-1:0] offset_s;

   assign queue_busy_s = (count_r != '0);
   assign force_s      = (starve_r == STARVE_MAX) && queue_busy_s;
   assign mul_ready_s  = (count_r < FULL_COUNT);
   assign push_s       = iMulValid && mul_ready_s;
   assign pop_s        = (grant_s == GRANT_QUEUE);

   // Grant selection and next starvation count.
   always_comb begin
      grant_s       = GRANT_NONE;
      starve_next_s = '0;
      if (force_s) begin
         grant_s       = GRANT_QUEUE;
         starve_next_s = '0;
      end else if (iAluWriteEnable) begin
         grant_s = GRANT_ALU;
         if (!queue_busy_s) begin
            starve_next_s = '0;
         end else if (starve_r == STARVE_MAX) begin
            starve_next_s = STARVE_MAX;
         end else begin
            starve_next_s = starve_r + STARVE_ONE;
         end
      end else if (queue_busy_s) begin
         grant_s       = GRANT_QUEUE;
         starve_next_s = '0;
      end else begin
         grant_s       = GRANT_NONE;
         starve_next_s = '0;
      end
   end

   // Hazard: a pending write (queued or sitting on the RAM port) shadows either read address.
   always_comb begin
      offset_s = '0;
      hazard_s = write_enable_r &&
                 ((iReadAddress0 == write_address_r) || (iReadAddress1 == write_address_r));
      for (int i = 0; i < PEND_DEPTH; i++) begin
         offset_s = PTR_WIDTH'(i) - rd_ptr_r;
         if (({1'b0, offset_s} < count_r) &&
             ((iReadAddress0 == queue_addr_r[i]) || (iReadAddress1 == queue_addr_r[i]))) begin
            hazard_s = 1'b1;
         end else begin
            hazard_s = hazard_s;
         end
      end
   end

   // Multiplier queue storage and write pointer.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < PEND_DEPTH; i++) begin
            queue_addr_r[i] <= '0;
            queue_data_r[i] <= '0;
         end
         wr_ptr_r <= '0;
      end else if (push_s) begin
         queue_addr_r[wr_ptr_r] <= iMulAddress;
         queue_data_r[wr_ptr_r] <= iMulData;
         wr_ptr_r               <= wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_r <= wr_ptr_r;
      end
   end

   // Read pointer, occupancy and starvation counter.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rd_ptr_r <= '0;
         count_r  <= '0;
         starve_r <= '0;
      end else begin
         starve_r <= starve_next_s;
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + COUNT_ONE;
            2'b01:   count_r <= count_r - COUNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // RAM write-port registers; address and data hold when nothing is granted.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         write_enable_r  <= 1'b0;
         write_address_r <= '0;
         write_data_r    <= '0;
      end else begin
         case (grant_s)
            GRANT_ALU: begin
               write_enable_r  <= 1'b1;
               write_address_r <= iAluWriteAddress;
               write_data_r    <= iAluDataIn;
            end
            GRANT_QUEUE: begin
               write_enable_r  <= 1'b1;
               write_address_r <= queue_addr_r[rd_ptr_r];
               write_data_r    <= queue_data_r[rd_ptr_r];
            end
            default: begin
               write_enable_r  <= 1'b0;
               write_address_r <= write_address_r;
               write_data_r    <= write_data_r;
            end
         endcase
      end
   end

   assign oAluHold      = force_s;
   assign oMulReady     = mul_ready_s;
   assign oWriteEnable  = write_enable_r;
   assign oWriteAddress = write_address_r;
   assign oDataOut      = write_data_r;
   assign oStall        = hazard_s;
   assign oPendingCount = count_r;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Directed bench for ram_write_arbiter: priority, starvation forcing, FIFO order,
// hazard detection, full-queue back-pressure and asynchronous reset.
module tb_ram_write_arbiter;

   logic        Clock;
   logic        Reset;
   logic        iAluWriteEnable;
   logic [7:0]  iAluWriteAddress;
   logic [15:0] iAluDataIn;
   logic        oAluHold;
   logic        iMulValid;
   logic [7:0]  iMulAddress;
   logic [15:0] iMulData;
   logic        oMulReady;
   logic [7:0]  iReadAddress0;
   logic [7:0]  iReadAddress1;
   logic        oWriteEnable;
   logic [7:0]  oWriteAddress;
   logic [15:0] oDataOut;
   logic        oStall;
   logic [2:0]  oPendingCount;

   int checks = 0;
   int errors = 0;
   int d;

   ram_write_arbiter dut (
      .Clock(Clock), .Reset(Reset),
      .iAluWriteEnable(iAluWriteEnable), .iAluWriteAddress(iAluWriteAddress),
      .iAluDataIn(iAluDataIn), .oAluHold(oAluHold),
      .iMulValid(iMulValid), .iMulAddress(iMulAddress), .iMulData(iMulData),
      .oMulReady(oMulReady),
      .iReadAddress0(iReadAddress0), .iReadAddress1(iReadAddress1),
      .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress), .oDataOut(oDataOut),
      .oStall(oStall), .oPendingCount(oPendingCount)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      iAluWriteEnable = 1'b0; iAluWriteAddress = 8'h00; iAluDataIn = 16'h0000;
      iMulValid = 1'b0; iMulAddress = 8'h00; iMulData = 16'h0000;
      iReadAddress0 = 8'hF0; iReadAddress1 = 8'hF1;
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b0;
      settle();
      check("reset_we", oWriteEnable, 0);
      check("reset_addr", oWriteAddress, 0);
      check("reset_data", oDataOut, 0);
      check("reset_ready", oMulReady, 1);
      check("reset_hold", oAluHold, 0);
      check("reset_pend", oPendingCount, 0);
      check("reset_stall", oStall, 0);

      // single multiplier write, no ALU traffic
      iMulValid = 1'b1; iMulAddress = 8'd8; iMulData = 16'h1234;
      cyc();
      iMulValid = 1'b0;
      settle();
      check("single_pend1", oPendingCount, 1);
      check("single_we0", oWriteEnable, 0);
      cyc();
      check("single_we", oWriteEnable, 1);
      check("single_addr", oWriteAddress, 8);
      check("single_data", oDataOut, 16'h1234);
      check("single_pend0", oPendingCount, 0);
      cyc();
      check("single_idle_we", oWriteEnable, 0);
      check("single_idle_addr", oWriteAddress, 8);

      // ALU every cycle while four multiplier results queue up
      iAluWriteEnable = 1'b1; iAluWriteAddress = 8'd3; iAluDataIn = 16'h00AA;
      iMulValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         iMulAddress = 8'(8 + i);
         iMulData = 16'(16'h0C00 + i);
         cyc();
         check("starve_fill_addr", oWriteAddress, 3);
         check("starve_fill_pend", oPendingCount, 32'(i + 1));
      end
      iMulValid = 1'b0;
      settle();
      check("starve_full_ready", oMulReady, 0);
      check("starve_hold_early", oAluHold, 0);
      cyc();
      check("starve_alu4_addr", oWriteAddress, 3);
      check("starve_hold", oAluHold, 1);
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("forced_we", oWriteEnable, 1);
         check("forced_addr", oWriteAddress, 32'(8 + k));
         check("forced_data", oDataOut, 32'(16'h0C00 + k));
         check("forced_pend", oPendingCount, 32'(3 - k));
         check("forced_hold_clear", oAluHold, 0);
         if (k < 3) begin
            for (int j = 0; j < 4; j++) begin
               cyc();
               check("between_alu_addr", oWriteAddress, 3);
               check("between_alu_data", oDataOut, 16'h00AA);
            end
            check("between_hold", oAluHold, 1);
         end
      end
      iAluWriteEnable = 1'b0;
      cyc();
      check("drained_we", oWriteEnable, 0);
      check("drained_pend", oPendingCount, 0);

      // read-after-write hazard
      iAluWriteEnable = 1'b1; iAluWriteAddress = 8'd3; iAluDataIn = 16'h0055;
      iMulValid = 1'b1; iMulAddress = 8'd5; iMulData = 16'h5555;
      iReadAddress0 = 8'd6; iReadAddress1 = 8'hF1;
      settle();
      check("haz_empty", oStall, 0);
      cyc();
      iAluWriteEnable = 1'b0; iMulValid = 1'b0;
      settle();
      check("haz_pend", oPendingCount, 1);
      check("haz_no_match", oStall, 0);
      iReadAddress1 = 8'd5;
      settle();
      check("haz_queue_port1", oStall, 1);
      iReadAddress0 = 8'd5; iReadAddress1 = 8'hF1;
      settle();
      check("haz_queue_port0", oStall, 1);
      iReadAddress0 = 8'd6; iReadAddress1 = 8'd5;
      cyc();
      check("haz_wr_we", oWriteEnable, 1);
      check("haz_wr_addr", oWriteAddress, 5);
      check("haz_wr_data", oDataOut, 16'h5555);
      check("haz_outreg", oStall, 1);
      cyc();
      check("haz_clear_we", oWriteEnable, 0);
      check("haz_clear", oStall, 0);
      iReadAddress0 = 8'hF0; iReadAddress1 = 8'hF1;

      // full queue: pop while iMulValid, push blocked, then accepted next cycle
      iAluWriteEnable = 1'b1; iAluWriteAddress = 8'd3; iAluDataIn = 16'h00AA;
      iMulValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         iMulAddress = 8'(8'h10 + i);
         iMulData = 16'(i + 1);
         cyc();
         check("full_fill_pend", oPendingCount, 32'(i + 1));
      end
      iMulAddress = 8'h14; iMulData = 16'h0005;
      settle();
      check("full_ready0", oMulReady, 0);
      cyc();
      check("full_pend4", oPendingCount, 4);
      check("full_alu_addr", oWriteAddress, 3);
      cyc();
      check("full_pop_addr", oWriteAddress, 8'h10);
      check("full_pop_data", oDataOut, 1);
      check("full_no_push", oPendingCount, 3);
      check("full_ready1", oMulReady, 1);
      cyc();
      check("full_push_pend", oPendingCount, 4);
      check("full_push_alu", oWriteAddress, 3);

      // drain with ALU idle; multiplier keeps feeding 6..10 through the wrapping pointers
      iAluWriteEnable = 1'b0;
      d = 6;
      iMulAddress = 8'(8'h10 + d - 1); iMulData = 16'(d);
      for (int k = 0; k < 9; k++) begin
         settle();
         check("wrap_ready", oMulReady, (k != 0) ? 32'd1 : 32'd0);
         cyc();
         check("wrap_we", oWriteEnable, 1);
         check("wrap_data", oDataOut, 32'(k + 2));
         check("wrap_addr", oWriteAddress, 32'(8'h10 + k + 1));
         check("wrap_pend", oPendingCount, (k < 6) ? 32'd3 : 32'(8 - k));
         if (iMulValid && (k != 0)) begin
            d = d + 1;
            if (d > 10) begin
               iMulValid = 1'b0;
            end
            iMulAddress = 8'(8'h10 + d - 1); iMulData = 16'(d);
         end
      end
      iMulValid = 1'b0;

      // asynchronous reset with three entries queued and a write on the port
      iAluWriteEnable = 1'b1; iAluWriteAddress = 8'd3; iAluDataIn = 16'h00AA;
      iMulValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         iMulAddress = 8'(8'h40 + i);
         iMulData = 16'(16'h4000 + i);
         cyc();
      end
      iMulValid = 1'b0;
      iReadAddress0 = 8'h40;
      settle();
      check("prerst_pend", oPendingCount, 3);
      check("prerst_we", oWriteEnable, 1);
      check("prerst_stall", oStall, 1);
      Reset = 1'b1;
      settle();
      check("rst_we", oWriteEnable, 0);
      check("rst_addr", oWriteAddress, 0);
      check("rst_data", oDataOut, 0);
      check("rst_pend", oPendingCount, 0);
      check("rst_ready", oMulReady, 1);
      check("rst_stall", oStall, 0);
      iAluWriteEnable = 1'b0;
      @(posedge Clock);
      #3 Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("postrst_we", oWriteEnable, 0);
         check("postrst_pend", oPendingCount, 0);
         check("postrst_stall", oStall, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_write_arbiter.md
Name: ram_write_arbiter

Overview:
- Shares the register-file RAM's single write port between two requesters: the ALU writeback (priority) and the iterative multiplier result (queued).
- Sits between the execute stage and the dual-read-port RAM. Drives the RAM's write enable, address and data.
- Reports read-after-write hazards on both decode read addresses against every write not yet committed.

Parameters:
- DATA_WIDTH, 16, width of data words.
- ADDR_WIDTH, 8, width of register addresses.
- PTR_WIDTH, 2, multiplier queue pointer width; queue depth PEND_DEPTH = 2**PTR_WIDTH (4).
- STARVE_LIMIT, 4, consecutive ALU grants allowed while the queue is non-empty before the queue is forced through.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- iAluWriteEnable  in  1  ALU writeback request.
- iAluWriteAddress  in  ADDR_WIDTH  ALU destination register.
- iAluDataIn  in  DATA_WIDTH  ALU result.
- oAluHold  out  1  ALU request not accepted this cycle; pipeline must hold writeback.
- iMulValid  in  1  multiplier result valid.
- iMulAddress  in  ADDR_WIDTH  multiplier destination register.
- iMulData  in  DATA_WIDTH  multiplier result.
- oMulReady  out  1  queue can accept a multiplier result.
- iReadAddress0  in  ADDR_WIDTH  decode read address, port 0.
- iReadAddress1  in  ADDR_WIDTH  decode read address, port 1.
- oWriteEnable  out  1  to RAM write enable.
- oWriteAddress  out  ADDR_WIDTH  to RAM write address.
- oDataOut  out  DATA_WIDTH  to RAM write data.
- oStall  out  1  read-after-write hazard on either read address.
- oPendingCount  out  PTR_WIDTH+1  number of queued multiplier entries.

Behaviour:
- Reset (async, active-high):
  - oWriteEnable, oWriteAddress and oDataOut = 0.
  - Queue emptied; pointers = 0; oPendingCount = 0; starvation counter = 0.
  - oMulReady = 1 and oAluHold = 0 once reset deasserts.
  - Reset mid-operation discards all queued and registered writes. No RAM write is issued for them.
- Queue:
  - Circular buffer of PEND_DEPTH {address, data} entries.
  - oMulReady = (count < PEND_DEPTH), combinational from count. There is no push on full, even if a pop occurs in the same cycle.
  - Push on rising edge when iMulValid && oMulReady. iMulValid while not ready leaves the request pending; the multiplier holds its values.
  - Pointers wrap modulo PEND_DEPTH.
  - Simultaneous push and pop: count unchanged; pop returns the older head entry.
- Grant (evaluated combinationally, registered at the rising edge):
  - force = (starve_cnt == STARVE_LIMIT) && count != 0.
  - If force: the queue head is granted, oAluHold = 1, starve_cnt clears.
  - Else if iAluWriteEnable: the ALU is granted. starve_cnt increments if count != 0 (saturating at STARVE_LIMIT), otherwise it clears.
  - Else if count != 0: the queue head is granted; starve_cnt clears.
  - Else: no grant; oWriteEnable = 0 next cycle.
- Output registers:
  - Granted address and data are loaded into oWriteAddress and oDataOut with oWriteEnable = 1.
  - With no grant, oWriteEnable = 0 and address/data hold their previous values.
- Latency:
  - ALU write reaches the RAM port 1 cycle after request (RAM commits 2 edges after request).
  - Multiplier write: pushed at edge N, granted at earliest edge N+1, RAM commits at edge N+2.
- Ordering:
  - Writes to the same address commit in grant order. No merging or cancellation.
- Hazard (combinational):
  - oStall = 1 if iReadAddress0 or iReadAddress1 equals the address of any valid queue entry, or equals oWriteAddress while oWriteEnable = 1.
  - Reason: the RAM reads the old value on the edge that commits the write.
  - A current-cycle ALU request is not checked; the pipeline forwards it.
- oPendingCount = count, updated on the edge.

Test Plan:
- Reset then idle -> oWriteEnable = 0, oMulReady = 1, oPendingCount = 0, oStall = 0.
- Single mul push (addr 8, data 0x1234) with no ALU traffic -> oPendingCount = 1 next cycle; the following cycle oWriteEnable = 1, oWriteAddress = 8, oDataOut = 0x1234, oPendingCount = 0.
- ALU writes every cycle (addr 3, data 0x00AA) while mul pushes 4 entries (addr 8-11) -> oMulReady = 0 at count 4; after STARVE_LIMIT ALU grants, oAluHold = 1 for one cycle and entry addr 8 is written. The pattern repeats until the queue drains in FIFO order 8, 9, 10, 11.
- Queue holds addr 5; iReadAddress1 = 5 -> oStall = 1 until the cycle after the addr-5 write leaves oWriteEnable. iReadAddress0 = 6 alone -> oStall = 0.
- Full queue with simultaneous pop and iMulValid -> no push that cycle; push accepted the next cycle with oPendingCount back at 4. Pointer wrap is verified over 10 push/pop pairs with data 0x0001..0x000A arriving in order.
- Reset asserted with 3 entries queued and oWriteEnable = 1 -> all outputs 0 immediately (asynchronous); after release no stale write appears.
